// File: rtl/npc_gen.sv
// Next-PC generator: prioritised redirects, stall-held redirect, IF/ID flushes.
// Optional return-address stack built when NPC_RAS_EN is defined.
module npc_gen #(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0040,
  parameter int          RAS_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic        stall,
  input  logic        exc,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        jmp,
  input  logic [31:0] jmp_target,
  input  logic        call,
  input  logic [31:0] call_link,
  input  logic        ret,
  output logic [31:0] npc,
  output logic        flush_if,
  output logic        flush_id,
  output logic        pend_valid,
  output logic        ras_miss
);

  logic [31:0] seq_pc;
  logic        ret_hit;
  logic [31:0] ras_top;

  assign seq_pc = pc + 32'd4;

`ifdef NPC_RAS_EN
  localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CW = PW + 1;

  logic [31:0]   stk_q [RAS_DEPTH];
  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] top_idx;
  logic [PW-1:0] wr_idx;
  logic          wr_en;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] cnt_inc;
  logic          ras_miss_q, ras_miss_d;
  logic          ras_empty;

  assign top_idx   = ptr_q - PW'(1);
  assign ras_empty = (cnt_q == '0);
  assign ret_hit   = ret && !ras_empty;
  assign ras_top   = stk_q[top_idx];

  // Count saturates on overflow; the wrapped pointer overwrites the oldest slot
  assign cnt_inc = (cnt_q == CW'(RAS_DEPTH)) ? cnt_q : cnt_q + CW'(1);

  always_comb begin
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    wr_en      = 1'b0;
    wr_idx     = ptr_q;
    ras_miss_d = 1'b0;
    if (!stall) begin
      ras_miss_d = ret && ras_empty;
      if (call && ret_hit) begin
        wr_en  = 1'b1;
        wr_idx = top_idx;
      end else if (call) begin
        wr_en  = 1'b1;
        wr_idx = ptr_q;
        ptr_d  = ptr_q + PW'(1);
        cnt_d  = cnt_inc;
      end else if (ret_hit) begin
        ptr_d  = top_idx;
        cnt_d  = cnt_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q      <= '0;
      cnt_q      <= '0;
      ras_miss_q <= 1'b0;
      for (int i = 0; i < RAS_DEPTH; i++) begin
        stk_q[i] <= '0;
      end
    end else begin
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      ras_miss_q <= ras_miss_d;
      if (wr_en) begin
        stk_q[wr_idx] <= call_link;
      end
    end
  end

  assign ras_miss = ras_miss_q;
`else
  localparam int unused_depth = RAS_DEPTH;
  logic unused_ras;

  assign unused_ras = ^{call, call_link, ret};
  assign ret_hit    = 1'b0;
  assign ras_top    = '0;
  assign ras_miss   = 1'b0;
`endif

  logic [1:0]  inc_pri;
  logic [31:0] inc_tgt;

  always_comb begin
    inc_pri = 2'd0;
    inc_tgt = '0;
    if (exc) begin
      inc_pri = 2'd3;
      inc_tgt = EXC_VECTOR;
    end else if (br_taken) begin
      inc_pri = 2'd2;
      inc_tgt = br_target;
    end else if (jmp) begin
      inc_pri = 2'd1;
      inc_tgt = jmp_target;
    end else if (ret_hit) begin
      inc_pri = 2'd1;
      inc_tgt = ras_top;
    end
  end

  logic        pend_valid_q, pend_valid_d;
  logic [1:0]  pend_pri_q, pend_pri_d;
  logic [31:0] pend_tgt_q, pend_tgt_d;
  logic        take_inc;
  logic        use_pend;
  logic [1:0]  win_pri;
  logic [31:0] win_tgt;
  logic        redirect;

  assign take_inc = (inc_pri != 2'd0)
                 && (!pend_valid_q || inc_pri >= pend_pri_q);

  // A held redirect always has pri >= 1, so it also wins over "no request"
  assign use_pend = pend_valid_q && (pend_pri_q > inc_pri);
  assign win_pri  = use_pend ? pend_pri_q : inc_pri;
  assign win_tgt  = use_pend ? pend_tgt_q : inc_tgt;
  assign redirect = (win_pri != 2'd0);

  always_comb begin
    pend_valid_d = pend_valid_q;
    pend_pri_d   = pend_pri_q;
    pend_tgt_d   = pend_tgt_q;
    npc          = seq_pc;
    flush_if     = 1'b0;
    flush_id     = 1'b0;
    if (stall) begin
      npc = pc;
      if (take_inc) begin
        pend_valid_d = 1'b1;
        pend_pri_d   = inc_pri;
        pend_tgt_d   = inc_tgt;
      end
    end else begin
      pend_valid_d = 1'b0;
      pend_pri_d   = 2'd0;
      if (redirect) begin
        npc      = win_tgt;
        flush_if = 1'b1;
        flush_id = win_pri[1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_valid_q <= 1'b0;
      pend_pri_q   <= 2'd0;
      pend_tgt_q   <= '0;
    end else begin
      pend_valid_q <= pend_valid_d;
      pend_pri_q   <= pend_pri_d;
      pend_tgt_q   <= pend_tgt_d;
    end
  end

  assign pend_valid = pend_valid_q;

endmodule

// File: tb/tb_npc_gen.sv
// Directed self-checking bench for npc_gen.
// Linear stimulus, immediate assertions at each check point.
module tb_npc_gen;

  logic        clk;
  logic        rst;
  logic [31:0] pc;
  logic        stall;
  logic        exc;
  logic        br_taken;
  logic [31:0] br_target;
  logic        jmp;
  logic [31:0] jmp_target;
  logic        call;
  logic [31:0] call_link;
  logic        ret;
  logic [31:0] npc;
  logic        flush_if;
  logic        flush_id;
  logic        pend_valid;
  logic        ras_miss;

  int checks;
  int errors;

  npc_gen #(
    .EXC_VECTOR(32'h0000_0040),
    .RAS_DEPTH (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pc        (pc),
    .stall     (stall),
    .exc       (exc),
    .br_taken  (br_taken),
    .br_target (br_target),
    .jmp       (jmp),
    .jmp_target(jmp_target),
    .call      (call),
    .call_link (call_link),
    .ret       (ret),
    .npc       (npc),
    .flush_if  (flush_if),
    .flush_id  (flush_id),
    .pend_valid(pend_valid),
    .ras_miss  (ras_miss)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stall      = 1'b0;
    exc        = 1'b0;
    br_taken   = 1'b0;
    br_target  = '0;
    jmp        = 1'b0;
    jmp_target = '0;
    call       = 1'b0;
    call_link  = '0;
    ret        = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b0;
    pc     = 32'h0000_1000;
    idle();
    #3;
    chk("rst_pend", {31'd0, pend_valid}, 32'd0);
    chk("rst_miss", {31'd0, ras_miss}, 32'd0);
    chk("rst_npc", npc, 32'h0000_1004);
    chk("rst_fif", {31'd0, flush_if}, 32'd0);
    rst = 1'b1;
    step();

    // sequential wrap
    pc = 32'hFFFF_FFFC;
    #1;
    chk("wrap_npc", npc, 32'h0);
    chk("wrap_fif", {31'd0, flush_if}, 32'd0);
    chk("wrap_fid", {31'd0, flush_id}, 32'd0);
    step();

    // same-cycle priority
    pc = 32'h0000_1000;
    exc = 1'b1;
    br_taken = 1'b1; br_target = 32'h100;
    jmp = 1'b1; jmp_target = 32'h200;
    #1;
    chk("prio_npc", npc, 32'h40);
    chk("prio_fif", {31'd0, flush_if}, 32'd1);
    chk("prio_fid", {31'd0, flush_id}, 32'd1);
    step();

    // jump alone: IF flush only
    idle();
    jmp = 1'b1; jmp_target = 32'h200;
    #1;
    chk("jmp_npc", npc, 32'h200);
    chk("jmp_fif", {31'd0, flush_if}, 32'd1);
    chk("jmp_fid", {31'd0, flush_id}, 32'd0);
    step();

    // held: low then high
    idle();
    pc = 32'h0000_2000;
    stall = 1'b1;
    jmp = 1'b1; jmp_target = 32'h200;
    #1;
    chk("lh1_npc", npc, 32'h2000);
    chk("lh1_fif", {31'd0, flush_if}, 32'd0);
    chk("lh1_fid", {31'd0, flush_id}, 32'd0);
    step();
    chk("lh1_pend", {31'd0, pend_valid}, 32'd1);
    jmp = 1'b0;
    br_taken = 1'b1; br_target = 32'h300;
    #1;
    chk("lh2_npc", npc, 32'h2000);
    step();
    chk("lh2_pend", {31'd0, pend_valid}, 32'd1);
    br_taken = 1'b0;
    #1;
    chk("lh3_npc", npc, 32'h2000);
    step();
    chk("lh3_pend", {31'd0, pend_valid}, 32'd1);
    stall = 1'b0;
    #1;
    chk("lh_rel_npc", npc, 32'h300);
    chk("lh_rel_fif", {31'd0, flush_if}, 32'd1);
    chk("lh_rel_fid", {31'd0, flush_id}, 32'd1);
    step();
    chk("lh_after_pend", {31'd0, pend_valid}, 32'd0);
    chk("lh_after_npc", npc, 32'h2004);

    // held: high then low (low dropped)
    stall = 1'b1;
    br_taken = 1'b1; br_target = 32'h300;
    step();
    br_taken = 1'b0;
    jmp = 1'b1; jmp_target = 32'h500;
    #1;
    chk("hl_npc", npc, 32'h2000);
    step();
    idle();
    #1;
    chk("hl_rel_npc", npc, 32'h300);
    chk("hl_rel_fid", {31'd0, flush_id}, 32'd1);
    step();

    // tie on release: incoming equal priority wins
    stall = 1'b1;
    jmp = 1'b1; jmp_target = 32'h200;
    step();
    stall = 1'b0;
    jmp_target = 32'h600;
    #1;
    chk("tie_npc", npc, 32'h600);
    step();

    // held jump loses to incoming branch on release
    idle();
    stall = 1'b1;
    jmp = 1'b1; jmp_target = 32'h700;
    step();
    idle();
    br_taken = 1'b1; br_target = 32'h800;
    #1;
    chk("up_npc", npc, 32'h800);
    chk("up_fid", {31'd0, flush_id}, 32'd1);
    step();
    idle();

`ifdef NPC_RAS_EN
    call = 1'b1;
    call_link = 32'h10; #1;
    chk("call_npc", npc, 32'h2004);
    chk("call_fif", {31'd0, flush_if}, 32'd0);
    step();
    call_link = 32'h20; step();
    call_link = 32'h30; step();
    call_link = 32'h40; step();
    call_link = 32'h50; step();
    idle();
    ret = 1'b1;
    #1;
    chk("ret1_npc", npc, 32'h50);
    chk("ret1_fif", {31'd0, flush_if}, 32'd1);
    chk("ret1_fid", {31'd0, flush_id}, 32'd0);
    step();
    chk("ret1_miss", {31'd0, ras_miss}, 32'd0);
    chk("ret2_npc", npc, 32'h40);
    step();
    chk("ret3_npc", npc, 32'h30);
    step();
    chk("ret4_npc", npc, 32'h20);
    step();
    chk("ret5_npc", npc, 32'h2004);
    chk("ret5_fif", {31'd0, flush_if}, 32'd0);
    step();
    ret = 1'b0;
    chk("miss_pulse", {31'd0, ras_miss}, 32'd1);
    step();
    chk("miss_clear", {31'd0, ras_miss}, 32'd0);
`else
    call = 1'b1; call_link = 32'h10;
    ret = 1'b1;
    #1;
    chk("noras_npc", npc, 32'h2004);
    chk("noras_fif", {31'd0, flush_if}, 32'd0);
    step();
    chk("noras_miss", {31'd0, ras_miss}, 32'd0);
    idle();
    ret = 1'b1;
    #1;
    chk("noras_ret_npc", npc, 32'h2004);
    step();
    chk("noras_miss2", {31'd0, ras_miss}, 32'd0);
`endif
    idle();

    // reset mid-stall
    stall = 1'b1;
    br_taken = 1'b1; br_target = 32'h300;
    step();
    chk("rs_pend_set", {31'd0, pend_valid}, 32'd1);
    br_taken = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk("rs_pend_clr", {31'd0, pend_valid}, 32'd0);
    rst = 1'b1;
    step();
    stall = 1'b0;
    #1;
    chk("rs_npc", npc, 32'h2004);
    chk("rs_fif", {31'd0, flush_if}, 32'd0);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
